// File: rtl/multi_sel_seq.sv
// rtl/multi_sel_seq.sv - sequential shift-and-add constant multiplier, one product per coefficient per sample
module multi_sel_seq #(
    parameter int DW       = 8,
    parameter int NUM_COEF = 4,
    parameter int COEF_W   = 4,
    parameter logic [NUM_COEF*COEF_W-1:0] COEF = 16'h8731,
    localparam int IDX_W   = $clog2(NUM_COEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        d,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 input_grant,
    output logic [DW+COEF_W-1:0] out,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     out_idx,
    input  logic                 out_ready
);

    localparam int PW = DW + COEF_W;
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(NUM_COEF - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_step;
    logic [DW-1:0]      r_d;
    logic [PW-1:0]      r_out;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_out_idx;
    logic               r_grant;

    logic               w_issue;
    logic               w_last;
    logic               w_capture;
    logic [COEF_W-1:0]  w_coef;
    logic [PW-1:0]      w_prod;
    logic [COEF_W-1:0]  w_coef_tbl [NUM_COEF];

    for (genvar k = 0; k < NUM_COEF; k++) begin : g_coef
        assign w_coef_tbl[k] = COEF[k*COEF_W +: COEF_W];
    end

    assign w_issue   = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_last    = (r_step == LAST_STEP);
    assign in_ready  = (r_state == IDLE) || (w_issue && w_last);
    assign w_capture = in_valid && in_ready;
    assign w_coef    = w_coef_tbl[r_step];

    // Product of the held sample and the current coefficient, one shifted copy per set bit
    always_comb begin
        w_prod = '0;
        for (int j = 0; j < COEF_W; j++) begin
            if (w_coef[j]) begin
                w_prod = w_prod + (PW'(r_d) << j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_d         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_grant     <= 1'b0;
        end else begin
            r_grant <= w_capture;

            if (w_issue) begin
                r_out       <= w_prod;
                r_out_idx   <= r_step;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // A capture on the final issue cycle reloads d while w_prod still uses the old sample
            if (w_capture) begin
                r_d     <= d;
                r_step  <= '0;
                r_state <= RUN;
            end else if (w_issue) begin
                if (!w_last) begin
                    r_step <= r_step + 1'b1;
                end else begin
                    r_state <= IDLE;
                end
            end
        end
    end

    assign out         = r_out;
    assign out_valid   = r_out_valid;
    assign out_idx     = r_out_idx;
    assign input_grant = r_grant;

endmodule

// File: tb/tb_multi_sel_seq.sv
// tb/tb_multi_sel_seq.sv - scoreboard bench for multi_sel_seq, default and wide configurations
module tb_multi_sel_seq;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [7:0]  d;
    logic        in_valid, in_ready, input_grant, out_valid, out_ready;
    logic [11:0] out;
    logic [1:0]  out_idx;

    logic [11:0] d2;
    logic        in_valid2, in_ready2, input_grant2, out_valid2, out_ready2;
    logic [16:0] out2;
    logic [1:0]  out_idx2;

    multi_sel_seq u_dut (
        .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
        .input_grant(input_grant), .out(out), .out_valid(out_valid),
        .out_idx(out_idx), .out_ready(out_ready)
    );

    multi_sel_seq #(
        .DW(12), .NUM_COEF(3), .COEF_W(5), .COEF({5'd31, 5'd0, 5'd17})
    ) u_dut2 (
        .clk(clk), .rst(rst), .d(d2), .in_valid(in_valid2), .in_ready(in_ready2),
        .input_grant(input_grant2), .out(out2), .out_valid(out_valid2),
        .out_idx(out_idx2), .out_ready(out_ready2)
    );

    localparam int C1[4] = '{1, 3, 7, 8};
    localparam int C2[3] = '{17, 0, 31};

    int checks   = 0;
    int failures = 0;
    int q_val[$], q_idx[$], q2_val[$], q2_idx[$];
    bit cont_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input int v);
        for (int k = 0; k < 4; k++) begin
            q_val.push_back(v * C1[k]);
            q_idx.push_back(k);
        end
    endtask

    task automatic drain1(input int bound);
        int n = 0;
        while ((q_val.size() != 0 || out_valid) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain1_queue", 32'(q_val.size()), 0);
        chk("drain1_valid", 32'(out_valid), 0);
        tick();
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            chk("beat1_expected", 32'(q_val.size() != 0), 1);
            if (q_val.size() != 0) begin
                chk("out", 32'(out), q_val.pop_front());
                chk("out_idx", 32'(out_idx), q_idx.pop_front());
            end
        end
        if (cont_chk) chk("out_valid_continuous", 32'(out_valid), 1);
    end

    always @(negedge clk) begin
        if (out_valid2 && out_ready2) begin
            chk("beat2_expected", 32'(q2_val.size() != 0), 1);
            if (q2_val.size() != 0) begin
                chk("out2", 32'(out2), q2_val.pop_front());
                chk("out_idx2", 32'(out_idx2), q2_idx.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1; d = '0; in_valid = 1'b0; out_ready = 1'b1;
        d2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;

        @(negedge clk);
        chk("rst_out", 32'(out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_grant", 32'(input_grant), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        tick();
        rst = 1'b0;
        tick();

        // single sample, full-scale input
        d = 8'd255; in_valid = 1'b1; push1(255);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_grant_pulse", 32'(input_grant), 1);
        chk("t1_no_beat_yet", 32'(out_valid), 0);
        tick();
        @(negedge clk);
        chk("t1_grant_end", 32'(input_grant), 0);
        repeat (4) tick();
        @(negedge clk);
        chk("t1_valid_cleared", 32'(out_valid), 0);
        chk("t1_out_holds", 32'(out), 2040);
        chk("t1_idle_ready", 32'(in_ready), 1);
        drain1(20);

        // back-to-back samples, in_valid held high
        d = 8'd1; in_valid = 1'b1; push1(1);
        tick();
        d = 8'd10; push1(10);
        tick();
        cont_chk = 1'b1;
        @(negedge clk);
        chk("t2_busy_not_ready", 32'(in_ready), 0);
        tick();
        tick();
        @(negedge clk);
        chk("t2_ready_on_last", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_capture_at_idx3", 32'(out_idx), 3);
        chk("t2_second_grant", 32'(input_grant), 1);
        repeat (4) tick();
        @(negedge clk);
        cont_chk = 1'b0;
        drain1(20);

        // output stall at beat 1
        d = 8'd5; in_valid = 1'b1; push1(5);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_out", 32'(out), 15);
            chk("t3_stall_idx", 32'(out_idx), 1);
            chk("t3_stall_valid", 32'(out_valid), 1);
            chk("t3_stall_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        drain1(20);

        // asynchronous reset while beat 2 is on the output
        d = 8'd200; in_valid = 1'b1;
        q_val.push_back(200); q_idx.push_back(0);
        q_val.push_back(600); q_idx.push_back(1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        chk("t4_async_out", 32'(out), 0);
        chk("t4_async_valid", 32'(out_valid), 0);
        chk("t4_async_idx", 32'(out_idx), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_no_residual", 32'(out_valid), 0);
            chk("t4_idle_ready", 32'(in_ready), 1);
        end
        chk("t4_queue_empty", 32'(q_val.size()), 0);
        tick();

        // d/in_valid wiggled while busy must be ignored
        d = 8'd3; in_valid = 1'b1; push1(3);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = (i % 2 == 0);
            d = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("t6_busy_ignored", 32'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0;
        drain1(20);

        // wide configuration with a zero coefficient
        d2 = 12'd4095; in_valid2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            q2_val.push_back(4095 * C2[k]);
            q2_idx.push_back(k);
        end
        tick();
        in_valid2 = 1'b0;
        begin
            int n = 0;
            while ((q2_val.size() != 0 || out_valid2) && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t5_queue_empty", 32'(q2_val.size()), 0);
        chk("t5_final_out", 32'(out2), 126945);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
